fma16_issue: RTL and testbench

Operand issue stage directly upstream of the 16-bit floating-point multiply-accumulate datapath. Accepts opcode-tagged commands (x, y, z, rounding mode) over a valid/ready handshake, buffers them in a small FIFO, decodes the opcode into the datapath's mul/add/negr/negz controls, and presents one registered, fully decoded operation per cycle to the datapath. Illegal opcodes are dropped and reported.

---
 rtl/fma16_pkg.sv | 50 +++++
 rtl/fma16_issue_if.sv | 34 +++
 rtl/fma16_issue_fifo.sv | 53 +++++
 rtl/fma16_issue.sv | 108 ++++++++++
 tb/tb_fma16_issue.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fma16_pkg.sv
// Shared types for the fp16 multiply-accumulate issue stage: opcodes,
// rounding mode, decoded control bundle and the queued entry layout.
package fma16_pkg;

  typedef enum logic [2:0] {
    OP_FADD    = 3'd0,
    OP_FSUB    = 3'd1,
    OP_FMUL    = 3'd2,
    OP_FMADD   = 3'd3,
    OP_FMSUB   = 3'd4,
    OP_FNMADD  = 3'd5,
    OP_FNMSUB  = 3'd6,
    OP_ILLEGAL = 3'd7
  } op_e;

  typedef logic [1:0] roundmode_t;

  typedef struct packed {
    logic mul;
    logic add;
    logic negr;
    logic negz;
  } ctrl_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    roundmode_t  rm;
    ctrl_t       ctrl;
  } entry_t;

  // Illegal opcodes decode to all-zero controls; they never reach the queue.
  function automatic ctrl_t decode(input op_e op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_FADD:   c = 4'b0100;
      OP_FSUB:   c = 4'b0101;
      OP_FMUL:   c = 4'b1000;
      OP_FMADD:  c = 4'b1100;
      OP_FMSUB:  c = 4'b1101;
      OP_FNMADD: c = 4'b1110;
      OP_FNMSUB: c = 4'b1111;
      default:   c = 4'b0000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fma16_issue_if.sv
// Command and decoded-operation buses of the issue stage.
// Both sides use valid/ready: a transfer happens on a rising edge where valid & ready are both 1.
interface fma16_issue_if;
  import fma16_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [15:0] in_x;
  logic [15:0] in_y;
  logic [15:0] in_z;
  roundmode_t  in_rm;

  logic        out_valid;
  logic        out_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic [15:0] z;
  logic        mul;
  logic        add;
  logic        negr;
  logic        negz;
  roundmode_t  roundmode;

  modport master (
    output in_valid, in_op, in_x, in_y, in_z, in_rm, out_ready,
    input  in_ready, out_valid, x, y, z, mul, add, negr, negz, roundmode
  );

  modport slave (
    input  in_valid, in_op, in_x, in_y, in_z, in_rm, out_ready,
    output in_ready, out_valid, x, y, z, mul, add, negr, negz, roundmode
  );
endinterface

// File: rtl/fma16_issue_fifo.sv
// Circular buffer of decoded entries with occupancy count; flush is synchronous,
// reset asynchronous. Caller must not push when full or pop when empty.
module fma16_issue_fifo
  import fma16_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  entry_t           i_data,
  input  logic             i_pop,
  output entry_t           o_data,
  output logic [LVL_W-1:0] o_level
);

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;

  // Pointers are power-of-two wide, so natural overflow is the modulo-DEPTH wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_level = r_level;

endmodule

// File: rtl/fma16_issue.sv
// Operand issue stage: decodes commands at enqueue, queues them, presents one registered op per cycle.
// FMA16_ISSUE_BYPASS_EN: legal commands skip an empty queue straight into a free output register.
module fma16_issue
  import fma16_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int CNT_W = 8,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  fma16_issue_if.slave      bus,
  output logic [LVL_W-1:0]  level,
  output logic              err_illegal,
  output logic [CNT_W-1:0]  illegal_cnt
);

  logic [LVL_W-1:0] w_level;
  entry_t           w_in_entry;
  entry_t           w_head;
  logic             w_accept;
  logic             w_illegal;
  logic             w_out_free;
  logic             w_fifo_empty;
  logic             w_bypass;
  logic             w_push;
  logic             w_pop;

  entry_t           r_out;
  logic             r_out_valid;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  // in_ready looks only at the registered level, never at out_ready.
  assign bus.in_ready = (w_level != LVL_W'(DEPTH)) & ~flush;
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_illegal    = (op_e'(bus.in_op) == OP_ILLEGAL);
  assign w_in_entry   = '{x: bus.in_x, y: bus.in_y, z: bus.in_z, rm: bus.in_rm,
                          ctrl: decode(op_e'(bus.in_op))};
  assign w_out_free   = ~r_out_valid | bus.out_ready;
  assign w_fifo_empty = (w_level == '0);

`ifdef FMA16_ISSUE_BYPASS_EN
  assign w_bypass = w_accept & ~w_illegal & w_fifo_empty & w_out_free;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_accept & ~w_illegal & ~w_bypass;
  assign w_pop  = ~w_fifo_empty & w_out_free & ~flush;

  fma16_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_push  (w_push),
    .i_data  (w_in_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_level (w_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_pop) begin
      r_out       <= w_head;
      r_out_valid <= 1'b1;
    end else if (w_bypass) begin
      r_out       <= w_in_entry;
      r_out_valid <= 1'b1;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // The sticky flag clears on flush; the counter survives it and saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
      r_cnt <= '0;
    end else if (flush) begin
      r_err <= 1'b0;
    end else if (w_accept && w_illegal) begin
      r_err <= 1'b1;
      if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.x         = r_out.x;
  assign bus.y         = r_out.y;
  assign bus.z         = r_out.z;
  assign bus.roundmode = r_out.rm;
  assign bus.mul       = r_out.ctrl.mul;
  assign bus.add       = r_out.ctrl.add;
  assign bus.negr      = r_out.ctrl.negr;
  assign bus.negz      = r_out.ctrl.negz;

  assign level       = w_level;
  assign err_illegal = r_err;
  assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_fma16_issue.sv
// Directed bench for fma16_issue: queue-level reference model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_fma16_issue;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int LVL_W = 3;
`ifdef FMA16_ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  logic [LVL_W-1:0] level;
  logic             err_illegal;
  logic [CNT_W-1:0] illegal_cnt;

  fma16_issue_if bus ();

  fma16_issue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .bus         (bus),
    .level       (level),
    .err_illegal (err_illegal),
    .illegal_cnt (illegal_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // decoded controls {mul,add,negr,negz} by opcode
  logic [3:0] ctrl_tab [8] = '{4'b0100, 4'b0101, 4'b1000, 4'b1100,
                              4'b1101, 4'b1110, 4'b1111, 4'b0000};

  function automatic logic [53:0] mk(input logic [2:0] op, input logic [15:0] x, y, z,
                                     input logic [1:0] rm);
    return {x, y, z, rm, ctrl_tab[op]};
  endfunction

  // reference model: queue of waiting ops plus one output slot
  logic [53:0] exp_q[$];
  logic [53:0] m_out = '0;
  bit          m_ov  = 1'b0;
  bit          m_err = 1'b0;
  int          m_cnt = 0;
  bit          m_acc = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    bit acc, legal, free, byp;
    logic [53:0] e;
    if (!rst_n) begin
      exp_q.delete();
      m_out <= '0;
      m_ov  <= 1'b0;
      m_err <= 1'b0;
      m_cnt <= 0;
      m_acc <= 1'b0;
    end else begin
      acc   = bus.in_valid && (exp_q.size() < DEPTH) && !flush;
      legal = (bus.in_op != 3'd7);
      e     = mk(bus.in_op, bus.in_x, bus.in_y, bus.in_z, bus.in_rm);
      if (flush) begin
        exp_q.delete();
        m_ov  <= 1'b0;
        m_err <= 1'b0;
      end else begin
        free = !m_ov || bus.out_ready;
        byp  = BYP && acc && legal && (exp_q.size() == 0) && free;
        if (exp_q.size() > 0 && free) begin
          m_out <= exp_q.pop_front();
          m_ov  <= 1'b1;
        end else if (byp) begin
          m_out <= e;
          m_ov  <= 1'b1;
        end else if (bus.out_ready) begin
          m_ov <= 1'b0;
        end
        if (acc && !legal) begin
          m_err <= 1'b1;
          if (m_cnt < 255) m_cnt <= m_cnt + 1;
        end
        if (acc && legal && !byp) exp_q.push_back(e);
      end
      m_acc <= acc;
    end
  end

  // scoreboard compare, every cycle on the falling edge
  logic [15:0] log_x[$];
  logic [3:0]  log_c[$];

  always @(negedge clk) begin
    chk("in_ready", bus.in_ready, (exp_q.size() < DEPTH) && !flush);
    chk("level", level, exp_q.size());
    chk("out_valid", bus.out_valid, m_ov);
    chk("err_illegal", err_illegal, m_err);
    chk("illegal_cnt", illegal_cnt, m_cnt);
    if (m_ov)
      chk("out_data", {bus.x, bus.y, bus.z, bus.roundmode, bus.mul, bus.add, bus.negr, bus.negz},
          m_out);
    if (bus.out_valid && bus.out_ready) begin
      log_x.push_back(bus.x);
      log_c.push_back({bus.mul, bus.add, bus.negr, bus.negz});
    end
  end

  // driver tasks
  task automatic send(input logic [2:0] op, input logic [15:0] x, y, z, input logic [1:0] rm);
    bit done;
    done         = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_x     = x;
    bus.in_y     = y;
    bus.in_z     = z;
    bus.in_rm    = rm;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      #1;
      if (m_acc) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got no accept, expected accept within 200 cycles");
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [3:0] lit_c [7] = '{4'b0100, 4'b0101, 4'b1000, 4'b1100, 4'b1101, 4'b1110, 4'b1111};

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = 3'd0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_z      = '0;
    bus.in_rm     = '0;
    bus.out_ready = 1'b1;

    // reset values
    #12;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_data", {bus.x, bus.y, bus.z, bus.roundmode}, 0);
    chk("rst_ctrl", {bus.mul, bus.add, bus.negr, bus.negz}, 0);
    chk("rst_err", err_illegal, 0);
    chk("rst_cnt", illegal_cnt, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycles(2);

    // single fmadd, latency
    send(3'd3, 16'h3C00, 16'h4000, 16'h3800, 2'b01);
    idle();
    @(negedge clk);
    chk("t1_valid_first", bus.out_valid, BYP);
    if (!BYP) @(negedge clk);
    chk("t1_valid", bus.out_valid, 1);
    chk("t1_ctrl", {bus.mul, bus.add, bus.negr, bus.negz}, 4'b1100);
    chk("t1_x", bus.x, 16'h3C00);
    chk("t1_y", bus.y, 16'h4000);
    chk("t1_z", bus.z, 16'h3800);
    chk("t1_rm", bus.roundmode, 2'b01);
    cycles(3);

    // all legal opcodes back to back
    log_x.delete();
    log_c.delete();
    for (int i = 0; i < 7; i++) begin
      logic [2:0] op;
      op = 3'(i);
      send(op, 16'h1000 + 16'(i), 16'h2000 + 16'(i), 16'h3000 + 16'(i), op[1:0]);
    end
    idle();
    cycles(6);
    chk("t2_count", log_c.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < log_c.size()) begin
        chk("t2_ctrl", log_c[i], lit_c[i]);
        chk("t2_order", log_x[i], 16'h1000 + 16'(i));
      end
    end

    // backpressure: DEPTH queued plus one held
    bus.out_ready = 1'b0;
    log_x.delete();
    log_c.delete();
    for (int i = 0; i < 5; i++) send(3'd0, 16'h5000 + 16'(i), 16'h0001, 16'h0002, 2'b00);
    idle();
    @(negedge clk);
    chk("t3_level_full", level, 4);
    chk("t3_out_valid", bus.out_valid, 1);
    chk("t3_in_ready_full", bus.in_ready, 0);
    chk("t3_head_x", bus.x, 16'h5000);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t3_in_ready_before_pop", bus.in_ready, 0);
    @(negedge clk);
    chk("t3_in_ready_after_pop", bus.in_ready, 1);
    chk("t3_level_after_pop", level, 3);
    cycles(8);
    chk("t3_count", log_x.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < log_x.size()) chk("t3_order", log_x[i], 16'h5000 + 16'(i));

    // illegal opcode amid legal ones, then saturation
    log_x.delete();
    log_c.delete();
    send(3'd0, 16'h6001, 16'h0, 16'h0, 2'b10);
    send(3'd7, 16'h6002, 16'h0, 16'h0, 2'b10);
    send(3'd2, 16'h6003, 16'h0, 16'h0, 2'b11);
    idle();
    cycles(4);
    chk("t4_err", err_illegal, 1);
    chk("t4_cnt", illegal_cnt, 1);
    chk("t4_count", log_x.size(), 2);
    if (log_x.size() == 2) begin
      chk("t4_first", log_x[0], 16'h6001);
      chk("t4_second", log_x[1], 16'h6003);
    end
    for (int i = 0; i < 300; i++) send(3'd7, 16'(i), 16'h0, 16'h0, 2'b00);
    idle();
    cycles(1);
    chk("t4_cnt_sat", illegal_cnt, 255);
    chk("t4_err_sticky", err_illegal, 1);

    // flush with queued work and a command presented
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(3'd4, 16'h7000 + 16'(i), 16'h0, 16'h0, 2'b01);
    idle();
    @(negedge clk);
    chk("t5_level_pre", level, 3);
    chk("t5_valid_pre", bus.out_valid, 1);
    @(posedge clk);
    #1;
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_op    = 3'd1;
    bus.in_x     = 16'h7777;
    @(negedge clk);
    chk("t5_in_ready_flush", bus.in_ready, 0);
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t5_level", level, 0);
    chk("t5_valid", bus.out_valid, 0);
    chk("t5_err", err_illegal, 0);
    chk("t5_cnt_kept", illegal_cnt, 255);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    cycles(2);

    // asynchronous reset mid-stream
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(3'd5, 16'h8000 + 16'(i), 16'h1, 16'h2, 2'b11);
    idle();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #3;
    chk("t6_valid", bus.out_valid, 0);
    chk("t6_level", level, 0);
    chk("t6_data", {bus.x, bus.y, bus.z, bus.roundmode}, 0);
    chk("t6_ctrl", {bus.mul, bus.add, bus.negr, bus.negz}, 0);
    chk("t6_cnt", illegal_cnt, 0);
    chk("t6_in_ready", bus.in_ready, 1);
    #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t6_in_ready_after", bus.in_ready, 1);
    chk("t6_level_after", level, 0);
    @(posedge clk);
    #1;
    send(3'd6, 16'h9001, 16'h9002, 16'h9003, 2'b10);
    idle();
    cycles(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
